mips8_mem_bridge: RTL and testbench

- Memory access stage directly downstream of the mips8 multicycle controller.
- Takes the controller's memread/memwrite strobes plus the datapath address and write data, and runs a req/ack transaction to an external byte-wide memory with variable wait states.
- Returns registered read data (memdata) to the datapath, and a mem_ready stall signal that holds the controller FSM in its current state until the access completes.
- Adds a bus timeout with a sticky error flag.

---
 rtl/mips8_mem_bridge.sv | 123 ++++++++++++
 tb/tb_mips8_mem_bridge.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mips8_mem_bridge.sv
// mips8_mem_bridge: req/ack bridge from the mips8 controller to a byte-wide memory with wait states,
// bus timeout and sticky error flag. Define MIPS8_MEM_BRIDGE_RDBUF_EN for a one-entry read buffer.
module mips8_mem_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [ADDR_W-1:0] adr_i,
    input  logic [DATA_W-1:0] writedata_i,
    output logic [DATA_W-1:0] memdata_o,
    output logic              mem_ready_o,
    output logic              ext_req_o,
    output logic              ext_we_o,
    output logic [ADDR_W-1:0] ext_adr_o,
    output logic [DATA_W-1:0] ext_wdata_o,
    input  logic              ext_ack_i,
    input  logic [DATA_W-1:0] ext_rdata_i,
    output logic              bus_err_o
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [7:0]        cnt_d;
    logic [DATA_W-1:0] memdata_q;
    logic              ext_req_q;
    logic              ext_we_q;
    logic [ADDR_W-1:0] ext_adr_q;
    logic [DATA_W-1:0] ext_wdata_q;
    logic              bus_err_q;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              timeout;

    assign cnt_d   = cnt_q + 8'd1;
    assign timeout = ~ext_ack_i & (cnt_d == 8'(TIMEOUT));

`ifdef MIPS8_MEM_BRIDGE_RDBUF_EN
    logic              rb_valid_q;
    logic [ADDR_W-1:0] rb_tag_q;
    logic [DATA_W-1:0] rb_data_q;

    assign hit      = memread_i & ~memwrite_i & rb_valid_q & (rb_tag_q == adr_i);
    assign hit_data = rb_data_q;

    // Buffer fills on read ack, follows writes to its tag, and drops on timeout
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rb_valid_q <= 1'b0;
            rb_tag_q   <= '0;
            rb_data_q  <= '0;
        end else if (state_q == REQ) begin
            if (ext_ack_i && !ext_we_q) begin
                rb_valid_q <= 1'b1;
                rb_tag_q   <= ext_adr_q;
                rb_data_q  <= ext_rdata_i;
            end else if (ext_ack_i && rb_valid_q && rb_tag_q == ext_adr_q) begin
                rb_data_q  <= ext_wdata_q;
            end else if (timeout) begin
                rb_valid_q <= 1'b0;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // Access FSM: latch request, wait for ack or timeout, then one ready cycle
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            memdata_q   <= '0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_adr_q   <= '0;
            ext_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (memread_i || memwrite_i) begin
                    ext_adr_q   <= adr_i;
                    ext_wdata_q <= writedata_i;
                    ext_we_q    <= memwrite_i;
                    cnt_q       <= '0;
                    if (hit) begin
                        memdata_q <= hit_data;
                        state_q   <= DONE;
                    end else begin
                        ext_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: if (ext_ack_i) begin
                    if (!ext_we_q) memdata_q <= ext_rdata_i;
                    ext_req_q <= 1'b0;
                    state_q   <= DONE;
                end else if (timeout) begin
                    if (!ext_we_q) memdata_q <= '0;
                    bus_err_q <= 1'b1;
                    ext_req_q <= 1'b0;
                    state_q   <= ERR;
                end else begin
                    cnt_q <= cnt_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_ready_o = (state_q == IDLE) ? ~(memread_i | memwrite_i) : (state_q != REQ);
    assign memdata_o   = memdata_q;
    assign ext_req_o   = ext_req_q;
    assign ext_we_o    = ext_we_q;
    assign ext_adr_o   = ext_adr_q;
    assign ext_wdata_o = ext_wdata_q;
    assign bus_err_o   = bus_err_q;
endmodule

// File: tb/tb_mips8_mem_bridge.sv
// tb_mips8_mem_bridge: directed checks of the mips8 memory bridge (read, write, timeout, reset, read buffer)
module tb_mips8_mem_bridge;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       memread = 1'b0;
    logic       memwrite = 1'b0;
    logic [7:0] adr = '0;
    logic [7:0] writedata = '0;
    logic [7:0] memdata;
    logic       mem_ready;
    logic       ext_req;
    logic       ext_we;
    logic [7:0] ext_adr;
    logic [7:0] ext_wdata;
    logic       ext_ack = 1'b0;
    logic [7:0] ext_rdata = '0;
    logic       bus_err;
    int         errors = 0;
    int         checks = 0;
    int         n;

    mips8_mem_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .memread_i(memread), .memwrite_i(memwrite),
        .adr_i(adr), .writedata_i(writedata), .memdata_o(memdata), .mem_ready_o(mem_ready),
        .ext_req_o(ext_req), .ext_we_o(ext_we), .ext_adr_o(ext_adr), .ext_wdata_o(ext_wdata),
        .ext_ack_i(ext_ack), .ext_rdata_i(ext_rdata), .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a strobe for one cycle; returns at the negedge of the first REQ cycle
    task automatic start_access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        memread = rd; memwrite = wr; adr = a; writedata = wd;
        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0;
    endtask

    // Ack after n further cycles; returns at the negedge of the cycle after the ack
    task automatic ack_after(input int wait_cycles, input logic [7:0] d);
        repeat (wait_cycles) @(negedge clk);
        ext_ack = 1'b1; ext_rdata = d;
        @(negedge clk);
        ext_ack = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", mem_ready, 1);
        check("rst_req", ext_req, 0);
        check("rst_memdata", memdata, 8'h00);
        check("rst_err", bus_err, 0);

        // Read 0x10, ack two cycles after ext_req rises
        memread = 1'b1; adr = 8'h10; #1;
        check("rd_ready_comb", mem_ready, 0);
        @(negedge clk);
        memread = 1'b0;
        check("rd_req", ext_req, 1);
        check("rd_we", ext_we, 0);
        check("rd_adr", ext_adr, 8'h10);
        @(negedge clk);
        @(negedge clk);
        check("rd_stall", mem_ready, 0);
        ack_after(0, 8'hA5);
        check("rd_done_ready", mem_ready, 1);
        check("rd_memdata", memdata, 8'hA5);
        check("rd_done_req", ext_req, 0);
        @(negedge clk);

        // Write 0x20=0x3C, ack on first REQ cycle
        start_access(0, 1, 8'h20, 8'h3C);
        check("wr_req", ext_req, 1);
        check("wr_we", ext_we, 1);
        check("wr_wdata", ext_wdata, 8'h3C);
        check("wr_adr", ext_adr, 8'h20);
        check("wr_stall", mem_ready, 0);
        ack_after(0, 8'hEE);
        check("wr_done_ready", mem_ready, 1);
        check("wr_memdata_kept", memdata, 8'hA5);
        @(negedge clk);

        // Simultaneous read and write: write wins
        start_access(1, 1, 8'h30, 8'h5A);
        check("rw_we", ext_we, 1);
        check("rw_wdata", ext_wdata, 8'h5A);
        ack_after(0, 8'hEE);
        check("rw_memdata_kept", memdata, 8'hA5);
        @(negedge clk);

        // Ack outside REQ is ignored
        ext_ack = 1'b1; ext_rdata = 8'h66;
        @(negedge clk);
        ext_ack = 1'b0;
        check("idle_ack_req", ext_req, 0);
        check("idle_ack_memdata", memdata, 8'hA5);
        check("idle_ack_ready", mem_ready, 1);

        // Read with no ack: timeout after 15 REQ cycles
        start_access(1, 0, 8'h40, 8'h00);
        n = 0;
        while (ext_req === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", 8'(n), 8'd15);
        check("to_ready", mem_ready, 1);
        check("to_err", bus_err, 1);
        check("to_memdata", memdata, 8'h00);
        @(negedge clk);
        memread = 1'b1; adr = 8'h41; #1;
        check("to_idle_ready", mem_ready, 0);
        memread = 1'b0;
        check("to_err_sticky", bus_err, 1);

        // Normal read after error keeps bus_err
        start_access(1, 0, 8'h50, 8'h00);
        ack_after(0, 8'h99);
        check("post_to_memdata", memdata, 8'h99);
        check("post_to_err", bus_err, 1);
        @(negedge clk);

        // Ack on the 15th REQ cycle counts as success
        start_access(1, 0, 8'h60, 8'h00);
        ack_after(14, 8'h42);
        check("edge_ack_ready", mem_ready, 1);
        check("edge_ack_memdata", memdata, 8'h42);
        @(negedge clk);

        // Asynchronous reset mid-transaction
        start_access(1, 0, 8'h70, 8'h00);
        check("mid_req", ext_req, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_req", ext_req, 0);
        check("async_err", bus_err, 0);
        check("async_memdata", memdata, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", mem_ready, 1);
        start_access(1, 0, 8'h05, 8'h00);
        check("fresh_adr", ext_adr, 8'h05);
        check("fresh_req", ext_req, 1);
        ack_after(1, 8'h5E);
        check("fresh_memdata", memdata, 8'h5E);
        check("fresh_ready", mem_ready, 1);
        @(negedge clk);

`ifdef MIPS8_MEM_BRIDGE_RDBUF_EN
        start_access(1, 0, 8'h10, 8'h00);
        check("rb_miss_req", ext_req, 1);
        ack_after(0, 8'h77);
        check("rb_miss_memdata", memdata, 8'h77);
        @(negedge clk);
        start_access(1, 0, 8'h10, 8'h00);
        check("rb_hit_req", ext_req, 0);
        check("rb_hit_ready", mem_ready, 1);
        check("rb_hit_memdata", memdata, 8'h77);
        @(negedge clk);
        start_access(0, 1, 8'h10, 8'h11);
        ack_after(0, 8'h00);
        @(negedge clk);
        start_access(1, 0, 8'h10, 8'h00);
        check("rb_wr_hit_req", ext_req, 0);
        check("rb_wr_hit_memdata", memdata, 8'h11);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
